prefix_addsub_pipe: RTL
=======================

// Module: prefix_addsub_pipe
// PURPOSE
//  Pipelined Kogge-Stone adder/subtractor: computes A+B or A-B (A + ~B + 1) on WIDTH-bit operands.
//  One register rank per prefix level, with valid/ready on both ends.
//  Datapath unit that feeds the generate/propagate tree from operands and consumes its group carries.
//  Forms the registered arithmetic slice used by accumulators and comparators downstream.
// PARAMETERS
//  WIDTH   16               operand/result width, power of two, >=2
//  LEVEL   $clog2(WIDTH)    prefix levels (localparam, not overridable)
// PORTS
//  i_Clk      in   1      clock, all state on rising edge
//  i_Rst_n    in   1      asynchronous active-low reset
//  i_Valid    in   1      operand beat valid
//  o_Ready    out  1      block accepts beat this cycle
//  i_A        in   WIDTH  operand A
//  i_B        in   WIDTH  operand B
//  i_Sub      in   1      1: A-B, 0: A+B
//  o_Valid    out  1      result valid
//  i_Ready    in   1      downstream accepts result
//  o_Sum      out  WIDTH  result, mod 2^WIDTH
//  o_Cout     out  1      carry out (subtract: 1 = no borrow)
//  o_Ovf      out  1      signed overflow (see CONFIGURATION)
//  o_Zero     out  1      o_Sum == 0 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, o_Valid=0, o_Sum=0, o_Cout=0, o_Ovf=0, o_Zero=0.
//  - Stages:
//    - S0: registers bit p=A^B', g=A&B' (B'=i_Sub?~i_B:i_B), cin=i_Sub folded in as g0|=p0&cin; raw p0 also kept.
//    - S1..SLEVEL: level k combines node j with node j-2^(k-1) for j>=2^(k-1); lower nodes pass through.
//    - Output rank: sum_i = p_i ^ c_i, with c_0=cin and c_i=G[i-1:0]; Cout=G[WIDTH-1:0].
//    - Raw p vector, cin and operand MSBs travel with each stage.
//  - Single global advance: adv = ~o_Valid | i_Ready; o_Ready = adv (combinational from i_Ready and o_Valid).
//  - Every rank, including its valid bit, loads only when adv=1; else the whole pipe holds.
//  - Beat accepted when i_Valid & o_Ready.
//  - Latency: accepted at edge k -> o_Valid=1 after edge k+LEVEL+1 (WIDTH=16: 5 edges).
//  - Throughput 1 beat/clock when i_Ready held 1; order preserved.
//  - Bubbles (i_Valid=0 while adv) propagate as valid=0 slots; they are not collapsed.
//  - o_Sum/o_Cout/flags stable while o_Valid=1 & i_Ready=0. Output rank loads zeros-with-valid=0 only when the slot is empty.
//  - Simultaneous output consume and input accept in the same cycle is legal; full rate, no loss.
//  - Reset mid-operation: all in-flight beats discarded; no result emerges after release.
//  - Wrap: A+B overflow wraps mod 2^WIDTH; o_Cout reports carry. A-B with A<B (unsigned): o_Cout=0.
// CONFIGURATION
//  PREFIX_ADDSUB_FLAGS_EN defined:
//    - o_Ovf = (A[W-1]==B'[W-1]) & (Sum[W-1]!=A[W-1]).
//    - o_Zero = ~|Sum.
//    - Both registered in output rank, same timing as o_Sum.
//  Not defined:
//    - o_Ovf and o_Zero tied 0.
//    - Operand-MSB pipeline bits and flag logic not instantiated.
// TESTING (WIDTH=16)
//  - Add 0x1234+0x0FCC, i_Ready=1 -> 5 edges later o_Sum=0x2200, o_Cout=0, o_Zero=0.
//  - Sub 0x0005-0x0007 -> o_Sum=0xFFFE, o_Cout=0, o_Ovf=0. Sub 0x0007-0x0005 -> 0x0002, o_Cout=1.
//  - Add 0xFFFF+0x0001 -> o_Sum=0x0000, o_Cout=1, o_Zero=1 (flags build).
//  - Add 0x7FFF+0x0001 -> 0x8000, o_Ovf=1. Sub 0x8000-0x0001 -> 0x7FFF, o_Ovf=1 (flags build). Both flags 0 in non-flags build.
//  - Stream 8 random beats back-to-back, i_Ready=0 for cycles 3..6 -> o_Ready low while stalled.
//    Outputs held; all 8 results match model in order, none lost or duplicated.
//  - 3 beats in flight, pulse i_Rst_n low -> o_Valid=0 immediately.
//    After release no stale result appears; next beat returns with full latency.

Source files
------------

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor, one register rank per prefix level, valid/ready on both ends.
// Optional overflow/zero flags are built when PREFIX_ADDSUB_FLAGS_EN is defined.
module prefix_addsub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Sub,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_Ovf,
    output logic             o_Zero
);

    localparam int LEVEL = $clog2(WIDTH);

    // One global advance: the whole pipe moves together or holds together.
    logic adv;
    assign adv     = ~o_Valid | i_Ready;
    assign o_Ready = adv;

    // Rank 0 is the p/g rank, rank k holds the result of prefix level k.
    logic [WIDTH-1:0] g_q    [LEVEL+1];
    logic [WIDTH-1:0] p_q    [LEVEL+1];
    logic [WIDTH-1:0] praw_q [LEVEL+1];
    logic [LEVEL:0]   cin_q;
    logic [LEVEL:0]   valid_q;

    logic [WIDTH-1:0] g_d    [LEVEL+1];
    logic [WIDTH-1:0] p_d    [LEVEL+1];
    logic [WIDTH-1:0] praw_d [LEVEL+1];
    logic [LEVEL:0]   cin_d;
    logic [LEVEL:0]   valid_d;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
        b_eff = i_Sub ? ~i_B : i_B;
        p_in  = i_A ^ b_eff;
        g_in  = i_A & b_eff;
        g_in[0] = g_in[0] | (p_in[0] & i_Sub);

        g_d[0]     = g_in;
        p_d[0]     = p_in;
        praw_d[0]  = p_in;
        cin_d[0]   = i_Sub;
        valid_d[0] = i_Valid;

        for (int k = 1; k <= LEVEL; k++) begin
            g_d[k]     = g_q[k-1];
            p_d[k]     = p_q[k-1];
            praw_d[k]  = praw_q[k-1];
            cin_d[k]   = cin_q[k-1];
            valid_d[k] = valid_q[k-1];
            for (int j = 0; j < WIDTH; j++) begin
                if (j >= (1 << (k-1))) begin
                    g_d[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j - (1 << (k-1))]);
                    p_d[k][j] = p_q[k-1][j] & p_q[k-1][j - (1 << (k-1))];
                end
            end
        end
    end

    // NOTE: datapath ranks carry no reset; only the valid bits need a known value, which keeps the arrays plain flops.
    always_ff @(posedge i_Clk) begin
        if (adv) begin
            g_q    <= g_d;
            p_q    <= p_d;
            praw_q <= praw_d;
            cin_q  <= cin_d;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every rank samples the previous rank's old value.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0]; bit 0 takes the raw carry-in.
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    assign sum_d  = praw_q[LEVEL] ^ {g_q[LEVEL][WIDTH-2:0], cin_q[LEVEL]};
    assign cout_d = g_q[LEVEL][WIDTH-1];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Valid <= 1'b0;
            o_Sum   <= '0;
            o_Cout  <= 1'b0;
        end else if (adv) begin
            o_Valid <= valid_q[LEVEL];
            o_Sum   <= valid_q[LEVEL] ? sum_d  : '0;
            o_Cout  <= valid_q[LEVEL] ? cout_d : 1'b0;
        end
    end

`ifdef PREFIX_ADDSUB_FLAGS_EN
    // Operand sign bits ride alongside the prefix ranks for the overflow test.
    logic [LEVEL:0] a_msb_q;
    logic [LEVEL:0] b_msb_q;
    logic [LEVEL:0] a_msb_d;
    logic [LEVEL:0] b_msb_d;
    logic           ovf_d;
    logic           zero_d;

    assign a_msb_d = {a_msb_q[LEVEL-1:0], i_A[WIDTH-1]};
    assign b_msb_d = {b_msb_q[LEVEL-1:0], b_eff[WIDTH-1]};
    assign ovf_d   = (a_msb_q[LEVEL] == b_msb_q[LEVEL]) & (sum_d[WIDTH-1] != a_msb_q[LEVEL]);
    assign zero_d  = ~|sum_d;

    always_ff @(posedge i_Clk) begin
        if (adv) begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Ovf  <= 1'b0;
            o_Zero <= 1'b0;
        end else if (adv) begin
            o_Ovf  <= valid_q[LEVEL] ? ovf_d  : 1'b0;
            o_Zero <= valid_q[LEVEL] ? zero_d : 1'b0;
        end
    end
`else
    assign o_Ovf  = 1'b0;
    assign o_Zero = 1'b0;
`endif

endmodule
